// File: rtl/lcd_timing_gen.sv
// LCD panel timing generator: line/frame sync, data enable, pixel coordinates
// and vertical-compare strobe, driven from shadowed LCD_TIMH/LCD_TIMV settings.
//
// state  | meaning
// H_SYNC | line pulse active (hsw ticks)
// H_BP   | horizontal back porch (hbp ticks)
// H_ACT  | active pixels, pix_x counts 0..ppl-1
// H_FP   | horizontal front porch (hfp ticks); its last tick ends the line
// V_SYNC | frame pulse active (vsw lines)
// V_BP   | vertical back porch (vbp lines, skipped when 0)
// V_ACT  | active lines, pix_y counts 0..lpp-1
// V_FP   | vertical front porch (vfp lines, skipped when 0); its last line ends the frame
module lcd_timing_gen #(
    parameter int XW = 10,
    parameter int YW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pclk_en,
    input  logic          lcd_en,
    input  logic [1:0]    vcomp_sel,
    input  logic [31:0]   timh,
    input  logic [31:0]   timv,
    input  logic          pol_ivs,
    input  logic          pol_ihs,
    output logic          lcd_fp,
    output logic          lcd_lp,
    output logic          lcd_enab,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          frame_start,
    output logic          vcomp_irq
);

    localparam logic [1:0] H_SYNC = 2'd0;
    localparam logic [1:0] H_BP   = 2'd1;
    localparam logic [1:0] H_ACT  = 2'd2;
    localparam logic [1:0] H_FP   = 2'd3;

    localparam logic [1:0] V_SYNC = 2'd0;
    localparam logic [1:0] V_BP   = 2'd1;
    localparam logic [1:0] V_ACT  = 2'd2;
    localparam logic [1:0] V_FP   = 2'd3;

    logic          running;
    logic [1:0]    h_state, v_state;
    logic [8:0]    h_cnt;
    logic [7:0]    v_cnt;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic [31:2]   sh_timh;
    logic [31:0]   sh_timv;

    logic [1:0]    n_h, n_v;
    logic [8:0]    n_hc;
    logic [7:0]    n_vc;
    logic [XW-1:0] n_x;
    logic [YW-1:0] n_y;
    logic          n_fs, n_irq, load_sh, line_end, wrap;
    logic          h_end, v_end, n_act;
    logic [XW-1:0] ppl_m1;
    logic [YW-1:0] lpp_m1;
    logic          tim_unused;

    assign tim_unused = ^timh[1:0];

    assign ppl_m1 = XW'({sh_timh[7:2], 4'hF});
    assign lpp_m1 = YW'(sh_timv[9:0]);

    assign h_end = (h_state == H_ACT) ? (x_cnt == ppl_m1) : (h_cnt == 9'd0);
    assign v_end = (v_state == V_ACT) ? (y_cnt == lpp_m1) : (v_cnt == 8'd0);

    always_comb begin
        n_h      = h_state;
        n_hc     = h_cnt;
        n_x      = x_cnt;
        n_v      = v_state;
        n_vc     = v_cnt;
        n_y      = y_cnt;
        n_fs     = 1'b0;
        n_irq    = 1'b0;
        load_sh  = 1'b0;
        line_end = 1'b0;
        wrap     = 1'b0;

        if (running) begin
            if (!h_end) begin
                if (h_state == H_ACT) n_x  = x_cnt + 1'b1;
                else                  n_hc = h_cnt - 1'b1;
            end else begin
                case (h_state)
                    H_SYNC: begin n_h = H_BP;  n_hc = 9'(sh_timh[31:24]); end
                    H_BP:   begin n_h = H_ACT; n_x  = '0; end
                    H_ACT:  begin n_h = H_FP;  n_hc = 9'(sh_timh[23:16]); end
                    default: begin
                        n_h      = H_SYNC;
                        n_hc     = 9'(sh_timh[15:8]);
                        line_end = 1'b1;
                    end
                endcase
            end

            if (line_end) begin
                if (!v_end) begin
                    if (v_state == V_ACT) n_y  = y_cnt + 1'b1;
                    else                  n_vc = v_cnt - 1'b1;
                end else begin
                    case (v_state)
                        V_SYNC: begin
                            if (sh_timv[31:24] != 8'd0) begin
                                n_v   = V_BP;
                                n_vc  = sh_timv[31:24] - 8'd1;
                                n_irq = (vcomp_sel == 2'd1);
                            end else begin
                                n_v   = V_ACT;
                                n_y   = '0;
                                n_irq = (vcomp_sel == 2'd2);
                            end
                        end
                        V_BP: begin
                            n_v   = V_ACT;
                            n_y   = '0;
                            n_irq = (vcomp_sel == 2'd2);
                        end
                        V_ACT: begin
                            if (sh_timv[23:16] != 8'd0) begin
                                n_v   = V_FP;
                                n_vc  = sh_timv[23:16] - 8'd1;
                                n_irq = (vcomp_sel == 2'd3);
                            end else begin
                                wrap = 1'b1;
                            end
                        end
                        default: wrap = 1'b1;
                    endcase
                end
            end
        end

        // A new frame takes its first-line lengths straight from the live registers,
        // since the shadow copy only updates on this same tick.
        if (!running || wrap) begin
            n_h     = H_SYNC;
            n_hc    = 9'(timh[15:8]);
            n_x     = '0;
            n_v     = V_SYNC;
            n_vc    = 8'(timv[15:10]);
            n_y     = '0;
            n_fs    = 1'b1;
            n_irq   = (vcomp_sel == 2'd0);
            load_sh = 1'b1;
        end
    end

    assign n_act = (n_h == H_ACT) && (n_v == V_ACT);

    always_ff @(posedge clk) begin
        if (reset) begin
            running     <= 1'b0;
            h_state     <= H_SYNC;
            v_state     <= V_SYNC;
            h_cnt       <= '0;
            v_cnt       <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            sh_timh     <= '0;
            sh_timv     <= '0;
            lcd_fp      <= 1'b0;
            lcd_lp      <= 1'b0;
            lcd_enab    <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            vcomp_irq   <= 1'b0;
        end else if (!lcd_en || (!running && !pclk_en)) begin
            running     <= 1'b0;
            h_state     <= H_SYNC;
            v_state     <= V_SYNC;
            h_cnt       <= '0;
            v_cnt       <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            lcd_fp      <= pol_ivs;
            lcd_lp      <= pol_ihs;
            lcd_enab    <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            vcomp_irq   <= 1'b0;
        end else if (pclk_en) begin
            running     <= 1'b1;
            h_state     <= n_h;
            v_state     <= n_v;
            h_cnt       <= n_hc;
            v_cnt       <= n_vc;
            x_cnt       <= n_x;
            y_cnt       <= n_y;
            if (load_sh) begin
                sh_timh <= timh[31:2];
                sh_timv <= timv;
            end
            lcd_fp      <= (n_v == V_SYNC) ^ pol_ivs;
            lcd_lp      <= (n_h == H_SYNC) ^ pol_ihs;
            lcd_enab    <= n_act;
            pix_x       <= n_act ? n_x : '0;
            pix_y       <= n_act ? n_y : '0;
            frame_start <= n_fs;
            vcomp_irq   <= n_irq;
        end else begin
            frame_start <= 1'b0;
            vcomp_irq   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: directed panel scenarios plus randomized configs,
// checked every clk against a frame-position model (tick index -> expected outputs).
module tb_lcd_timing_gen;

    logic        clk = 1'b0;
    logic        reset, pclk_en, lcd_en, pol_ivs, pol_ihs;
    logic [1:0]  vcomp_sel;
    logic [31:0] timh, timv;
    logic        lcd_fp, lcd_lp, lcd_enab, frame_start, vcomp_irq;
    logic [9:0]  pix_x, pix_y;

    always #5 clk = ~clk;

    lcd_timing_gen #(.XW(10), .YW(10)) dut (
        .clk(clk), .reset(reset), .pclk_en(pclk_en), .lcd_en(lcd_en),
        .vcomp_sel(vcomp_sel), .timh(timh), .timv(timv),
        .pol_ivs(pol_ivs), .pol_ihs(pol_ihs),
        .lcd_fp(lcd_fp), .lcd_lp(lcd_lp), .lcd_enab(lcd_enab),
        .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .vcomp_irq(vcomp_irq)
    );

    int    n_vec = 0, n_err = 0;
    string tag;

    // model: frame config latched at frame start, tick index within the frame
    bit          m_run;
    int          m_n;
    int          c_ppl, c_hsw, c_hbp, c_hfp, c_lpp, c_vsw, c_vbp, c_vfp;
    logic [24:0] m_exp;
    int          cnt_en, cnt_fs, cnt_irq;

    task automatic check_vec(input string t, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", t, got, exp, $time);
        end
    endtask

    function automatic void latch_cfg();
        c_ppl = 16 * (int'(timh[7:2]) + 1);
        c_hsw = int'(timh[15:8]) + 1;
        c_hfp = int'(timh[23:16]) + 1;
        c_hbp = int'(timh[31:24]) + 1;
        c_lpp = int'(timv[9:0]) + 1;
        c_vsw = int'(timv[15:10]) + 1;
        c_vfp = int'(timv[23:16]);
        c_vbp = int'(timv[31:24]);
    endfunction

    function automatic int line_len();
        return c_hsw + c_hbp + c_ppl + c_hfp;
    endfunction

    function automatic int frame_len();
        return line_len() * (c_vsw + c_vbp + c_lpp + c_vfp);
    endfunction

    function automatic logic [24:0] calc(int n);
        int  line, h, x, y;
        bit  hs, vs, hact, vact, en, irq;
        line = n / line_len();
        h    = n % line_len();
        hs   = h < c_hsw;
        hact = (h >= c_hsw + c_hbp) && (h < c_hsw + c_hbp + c_ppl);
        vs   = line < c_vsw;
        vact = (line >= c_vsw + c_vbp) && (line < c_vsw + c_vbp + c_lpp);
        x    = h - c_hsw - c_hbp;
        y    = line - c_vsw - c_vbp;
        en   = hact && vact;
        case (vcomp_sel)
            2'd0:    irq = (line == 0);
            2'd1:    irq = (c_vbp > 0) && (line == c_vsw);
            2'd2:    irq = (line == c_vsw + c_vbp);
            default: irq = (c_vfp > 0) && (line == c_vsw + c_vbp + c_lpp);
        endcase
        irq = irq && (h == 0);
        return {vs ^ pol_ivs, hs ^ pol_ihs, en, n == 0, irq,
                en ? 10'(x) : 10'd0, en ? 10'(y) : 10'd0};
    endfunction

    task automatic cyc();
        if (reset) begin
            m_run = 0;
            m_exp = '0;
        end else if (!lcd_en) begin
            m_run = 0;
            m_exp = {pol_ivs, pol_ihs, 23'd0};
        end else if (pclk_en) begin
            if (!m_run) begin
                m_run = 1;
                m_n   = 0;
                latch_cfg();
            end else begin
                m_n++;
                if (m_n == frame_len()) begin
                    m_n = 0;
                    latch_cfg();
                end
            end
            m_exp = calc(m_n);
        end else if (!m_run) begin
            m_exp = {pol_ivs, pol_ihs, 23'd0};
        end else begin
            m_exp[21:20] = 2'b00;
        end
        @(posedge clk);
        #1;
        check_vec(tag, {7'd0, lcd_fp, lcd_lp, lcd_enab, frame_start, vcomp_irq, pix_x, pix_y},
                  {7'd0, m_exp});
        cnt_en  += int'(lcd_enab);
        cnt_fs  += int'(frame_start);
        cnt_irq += int'(vcomp_irq);
    endtask

    task automatic restart();
        lcd_en = 1'b0;
        cyc();
        lcd_en  = 1'b1;
        cnt_en  = 0;
        cnt_fs  = 0;
        cnt_irq = 0;
    endtask

    function automatic void rand_cfg();
        timh = ($urandom_range(0, 3) << 24) | ($urandom_range(0, 3) << 16) |
               ($urandom_range(0, 3) << 8) | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
        timv = ($urandom_range(0, 2) << 24) | ($urandom_range(0, 2) << 16) |
               ($urandom_range(0, 2) << 10) | $urandom_range(0, 5);
    endfunction

    initial begin
        bit found;
        int dens;
        reset = 1'b1; lcd_en = 1'b0; pclk_en = 1'b0;
        pol_ivs = 1'b0; pol_ihs = 1'b0; vcomp_sel = 2'd0;
        timh = 32'h0; timv = 32'h0101_0003;
        m_run = 0; m_n = 0; m_exp = '0;
        cnt_en = 0; cnt_fs = 0; cnt_irq = 0;
        latch_cfg();

        tag = "reset";
        repeat (2) cyc();
        reset = 1'b0;
        tag = "idle";
        repeat (3) cyc();

        // 19-tick lines, 7-line frames, active lines 2..5
        tag = "s1";
        lcd_en = 1'b1; pclk_en = 1'b1;
        cnt_en = 0; cnt_fs = 0;
        repeat (399) cyc();
        check_vec("s1_frames", cnt_fs, 3);
        check_vec("s1_enab_ticks", cnt_en, 3 * 64);

        tag = "s2_idle";
        lcd_en = 1'b0; pol_ivs = 1'b1; pol_ihs = 1'b1;
        repeat (4) cyc();
        tag = "s2";
        lcd_en = 1'b1;
        repeat (2 * 133) cyc();
        pol_ivs = 1'b0; pol_ihs = 1'b0;

        tag = "s3";
        for (int s = 0; s < 4; s++) begin
            vcomp_sel = 2'(s);
            restart();
            repeat (2 * 133) cyc();
            check_vec("s3_irq_per_frame", cnt_irq, 2);
        end
        vcomp_sel = 2'd0;

        // mid-frame LPP change: 7-line frame then 11-line frame (342 ticks)
        tag = "s4";
        restart();
        repeat (50) cyc();
        timv = 32'h0101_0007;
        repeat (292) cyc();
        check_vec("s4_frames", cnt_fs, 2);
        check_vec("s4_enab_ticks", cnt_en, 64 + 128);
        cyc();
        check_vec("s4_third_frame_start", frame_start, 1);
        timv = 32'h0101_0003;

        tag = "s5";
        restart();
        found = 0;
        for (int i = 0; i < 500 && !found; i++) begin
            cyc();
            if (m_run && m_n == 4 * 19 + 2 + 5) found = 1;
        end
        check_vec("s5_reach_line4", found, 1);
        lcd_en = 1'b0;
        cyc();
        lcd_en = 1'b1;
        cyc();
        check_vec("s5_restart_fs", frame_start, 1);
        check_vec("s5_restart_fp", lcd_fp, 1);

        // pixel clock every 3rd clk, reset inside the active area
        tag = "s6";
        pclk_en = 1'b0;
        restart();
        found = 0;
        for (int k = 0; k < 3000 && !found; k++) begin
            pclk_en = (k % 3 == 0);
            cyc();
            if (m_run && m_n >= 2 * 19 + 2 + 3) found = 1;
        end
        check_vec("s6_reach_active", found, 1);
        reset = 1'b1;
        cyc();
        check_vec("s6_reset_outputs", {lcd_fp, lcd_lp, lcd_enab, pix_x, pix_y}, 0);
        reset = 1'b0;
        for (int k = 0; k < 600; k++) begin
            pclk_en = (k % 3 == 0);
            cyc();
        end

        tag = "rand";
        for (int r = 0; r < 25; r++) begin
            rand_cfg();
            vcomp_sel = 2'($urandom_range(0, 3));
            pol_ivs   = 1'($urandom_range(0, 1));
            pol_ihs   = 1'($urandom_range(0, 1));
            dens      = $urandom_range(30, 100);
            pclk_en   = 1'b0;
            restart();
            for (int k = 0; k < 1200; k++) begin
                pclk_en = ($urandom_range(0, 99) < dens);
                if (k == 600) rand_cfg();
                if ($urandom_range(0, 399) == 0) lcd_en = ~lcd_en;
                if ($urandom_range(0, 199) == 0) vcomp_sel = 2'($urandom_range(0, 3));
                reset = ($urandom_range(0, 999) == 0);
                cyc();
            end
            reset  = 1'b0;
            lcd_en = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
